// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared state encoding, timeout limit and word-align mask
package mem_access_stage_pkg;
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts ack-less MEM_WAIT cycles and flags the edge where the count reaches the limit
module mem_wait_timer
  import mem_access_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic ack,
  output logic timeout
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 8'd0;
    else if (start) cnt <= 8'd0;
    else if (run && !ack) cnt <= cnt + 8'd1;
  assign timeout = run && !ack && (cnt == TIMEOUT_LIMIT - 8'd1);
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage issuing one data-memory request at a time and registering writeback results
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        wb_sel,
  input  logic        reg_write,
  input  logic [4:0]  rd_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] output_reg_ALU,
  output logic [31:0] output_reg_mem,
  output logic        sel_dat,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_valid,
  output logic        err_timeout
);
  state_t state, state_d;
  logic accept, mem_op, done, timeout;
  logic [31:0] lat_alu;
  logic [4:0] lat_rd;
  logic lat_rw, lat_sel, lat_read;
  mem_wait_timer u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept && mem_op),
    .run(state == MEM_WAIT),
    .ack(dmem_ack),
    .timeout(timeout)
  );
  assign in_ready = (state == IDLE);
  always_comb begin
    mem_op = mem_read || mem_write;
    accept = in_valid && (state == IDLE);
    done = (state == MEM_WAIT) && (dmem_ack || timeout);
    state_d = (accept && mem_op) ? MEM_WAIT : done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= 32'd0;
      dmem_wdata <= 32'd0;
      output_reg_ALU <= 32'd0;
      output_reg_mem <= 32'd0;
      sel_dat <= 1'b0;
      wb_rd <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_valid <= 1'b0;
      err_timeout <= 1'b0;
      lat_alu <= 32'd0;
      lat_rd <= 5'd0;
      lat_rw <= 1'b0;
      lat_sel <= 1'b0;
      lat_read <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        lat_alu <= alu_result;
        lat_rd <= rd_addr;
        lat_rw <= reg_write;
        lat_sel <= wb_sel && !mem_write;
        lat_read <= mem_read && !mem_write;
        if (mem_op) begin
          dmem_req <= 1'b1;
          dmem_we <= mem_write;
          dmem_addr <= alu_result & WORD_MASK;
          dmem_wdata <= store_data;
        end else begin
          output_reg_ALU <= alu_result;
          sel_dat <= wb_sel;
          wb_rd <= rd_addr;
          wb_reg_write <= reg_write;
          wb_valid <= 1'b1;
        end
      end
      if (done) begin
        dmem_req <= 1'b0;
        output_reg_ALU <= lat_alu;
        sel_dat <= lat_sel;
        wb_rd <= lat_rd;
        wb_reg_write <= lat_rw;
        wb_valid <= 1'b1;
        if (!dmem_ack) begin
          output_reg_mem <= 32'd0;
          err_timeout <= 1'b1;
        end else if (lat_read) output_reg_mem <= dmem_rdata;
      end
    end
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have clk  input  1  single rising-edge clock.
REQ-002 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have in_valid  input  1  EX stage presents an instruction.
REQ-004 SHALL have in_ready  output  1  stage can accept an instruction this cycle.
REQ-005 SHALL have alu_result  input  32  ALU result / memory address.
REQ-006 SHALL have store_data  input  32  rt value for stores.
REQ-007 SHALL have mem_read, mem_write, wb_sel, reg_write  input  1 each  control bits; wb_sel=1 selects memory data at writeback.
REQ-008 SHALL have rd_addr  input  5  destination register.
REQ-009 SHALL have dmem_req, dmem_we  output  1 each  data-memory request / write enable.
REQ-010 SHALL have dmem_addr, dmem_wdata  output  32 each  memory address / write data.
REQ-011 SHALL have dmem_ack  input  1  and dmem_rdata  input  32  memory completion and read data.
REQ-012 SHALL have output_reg_ALU, output_reg_mem  output  32 each  registered results feeding Mux_Sel_Dat.
REQ-013 SHALL have sel_dat  output  1  writeback select for Mux_Sel_Dat.
REQ-014 SHALL have wb_rd  output  5, wb_reg_write  output  1, wb_valid  output  1, err_timeout  output  1.

Function
REQ-015 FSM states SHALL be IDLE and MEM_WAIT; in_ready SHALL be 1 in IDLE and 0 in MEM_WAIT.
REQ-016 Accept = in_valid & in_ready at a rising edge; the stage SHALL latch alu_result, store_data, rd_addr, reg_write, wb_sel.
REQ-017 Accept with mem_read=0 and mem_write=0: outputs SHALL update at that edge, with wb_valid=1 for exactly one cycle (latency 1) and output_reg_mem unchanged; state stays IDLE.
REQ-018 Accept with a memory operation: state SHALL go to MEM_WAIT, and at the same edge dmem_req=1, dmem_addr={alu_result[31:2],2'b00}, dmem_we=mem_write, and dmem_wdata=store_data SHALL be registered.
REQ-019 In MEM_WAIT, dmem_req, dmem_we, dmem_addr, and dmem_wdata SHALL hold stable until dmem_ack=1.
REQ-020 On dmem_ack in MEM_WAIT:
- dmem_req SHALL drop at that edge.
- For a read, output_reg_mem SHALL capture dmem_rdata.
- output_reg_ALU, sel_dat, wb_rd, and wb_reg_write SHALL load from the latched values.
- wb_valid SHALL pulse for 1 cycle.
- State SHALL return to IDLE.
REQ-021 Minimum memory-op latency SHALL be 2 cycles (accept edge to wb_valid), with one extra cycle per wait state.
REQ-022 dmem_ack in IDLE SHALL be ignored.
REQ-023 mem_read=1 and mem_write=1 together SHALL be treated as a write; sel_dat SHALL be forced 0 for that instruction.
REQ-024 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without ack.
REQ-025 When the counter reaches 255 without ack, the stage SHALL:
- complete the operation as in REQ-020 with output_reg_mem=0;
- drop dmem_req;
- set err_timeout (sticky until reset).
REQ-026 Between wb_valid pulses, all output_reg_* outputs and sel_dat SHALL hold their last values.
REQ-027 For a store, wb_reg_write SHALL pass through the latched reg_write; the stage does not modify it.

Reset
REQ-028 rst_n=0 SHALL immediately force:
- state IDLE;
- in_ready=1;
- dmem_req=0, dmem_we=0;
- dmem_addr, dmem_wdata, output_reg_ALU, output_reg_mem = 0;
- sel_dat, wb_rd, wb_reg_write, wb_valid = 0;
- err_timeout=0 and wait counter = 0.
REQ-029 Reset asserted mid-MEM_WAIT SHALL abandon the operation without a wb_valid pulse.

Structure
REQ-030 State encodings, TIMEOUT_LIMIT=255, and the word-align mask SHALL live in a shared package / include used by the datapath.
REQ-031 The wait counter with timeout compare SHALL be one sub-module, mem_wait_timer; everything else SHALL be flat.

Verification
REQ-032 ALU op: accept alu_result=0x0000_0010, wb_sel=0, rd=5 -> next cycle output_reg_ALU=0x10, sel_dat=0, wb_rd=5, wb_valid=1 for one cycle.
REQ-033 Load, 3 wait states: alu_result=0x0000_0103, rdata=0xDEAD_BEEF -> dmem_addr=0x100 and dmem_req held for 4 cycles; then output_reg_mem=0xDEADBEEF, sel_dat=1, and in_ready=0 throughout the wait.
REQ-034 Store with read+write set: store_data=0x1234_5678 -> dmem_we=1, dmem_wdata=0x12345678, sel_dat=0 after ack.
REQ-035 No ack for 255 cycles -> err_timeout=1, wb_valid pulse with output_reg_mem=0, state IDLE; err_timeout still 1 after the next instruction.
REQ-036 rst_n low during MEM_WAIT cycle 2 -> all outputs 0 asynchronously, no wb_valid; a stray dmem_ack after reset is ignored.
